pipelined_ripple_subtractor: RTL and testbench

Pipelined N-bit ripple-borrow subtractor computing Diff = A − B − Bin. It complements the combinational ripple-carry adder: it uses the same per-bit structural chain, built with generate loops, but with full-subtractor cells. Pipeline registers cut the borrow chain every STAGE_BITS bits, so wide subtractions close timing. It sits in the datapath wherever a throughput-of-one subtraction with valid/ready flow control is needed.

---
 rtl/pipelined_ripple_subtractor.sv | 194 +++++++++++++++++++
 tb/tb_pipelined_ripple_subtractor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_ripple_subtractor.sv
// -----------------------------------------------------------------------------
// pipelined_ripple_subtractor
//
// Purpose:
//   Pipelined N-bit ripple-borrow subtractor computing Diff = A - B - Bin
//   (mod 2^WIDTH). A chain of full-subtractor cells is cut every STAGE_BITS
//   bits by a pipeline register, so L = WIDTH / STAGE_BITS stages are used.
//   A beat enters stage 0 on the accepting edge and reaches the output
//   registers L-1 edges later. Flow control is valid/ready with one global
//   stall; bubbles are not collapsed.
//
// Data movement per stage k (bits [k*S +: S], S = STAGE_BITS):
//   - the S-bit slice of A and B is taken from the skew registers of stage k-1
//     (stage 0 takes it from the ports), together with the registered borrow
//   - resolved Diff bits accumulate: stage k holds Diff[(k+1)*S-1:0]
//   - still-unresolved upper operand bits ride along in per-stage registers
//
// Parameters:
//   WIDTH       operand width in bits (>= 2)
//   STAGE_BITS  bits resolved per stage (WIDTH % STAGE_BITS == 0)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand beat present
//   in_ready   block can accept a beat this cycle (combinational, = ~stall)
//   A, B       minuend, subtrahend
//   Bin        borrow in
//   out_valid  result beat present (last stage valid bit)
//   out_ready  downstream accepts result
//   Diff       A - B - Bin mod 2^WIDTH (last stage register)
//   Ovf        signed overflow, only when SUB_OVERFLOW_EN is defined
//   Bout       borrow out of the MSB; 1 when A < B + Bin (unsigned)
//
// Configuration macro:
//   SUB_OVERFLOW_EN  adds the registered Ovf output, aligned with Diff.
//                    Default build (undefined): no Ovf port, no extra logic.
// -----------------------------------------------------------------------------

// One-bit full subtractor: d = a - b - bi, bo = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module pipelined_ripple_subtractor #(
    parameter int WIDTH      = 8,
    parameter int STAGE_BITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
`ifdef SUB_OVERFLOW_EN
    output logic             Ovf,
`endif
    output logic             Bout
);

    localparam int S = STAGE_BITS;
    localparam int L = WIDTH / STAGE_BITS;

    // A valid result that is not taken freezes every stage in the same cycle.
    // An empty output slot never stalls, so bubbles keep draining.
    logic stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int DW = (k + 1) * S;   // Diff bits resolved after this stage
        localparam int RW = WIDTH - DW;    // operand bits still unresolved

        logic [S-1:0]  a_seg;
        logic [S-1:0]  b_seg;
        logic [S-1:0]  d_seg;
        logic [S:0]    bc;                 // borrow chain through this slice
        logic          valid_in;
        logic [DW-1:0] diff_d;

        logic          valid_q;
        logic          borrow_q;
        logic [DW-1:0] diff_q;

        // Per-bit ripple chain inside the slice.
        for (genvar j = 0; j < S; j++) begin : g_bit
            full_subtractor u_fs (
                .a  (a_seg[j]),
                .b  (b_seg[j]),
                .bi (bc[j]),
                .d  (d_seg[j]),
                .bo (bc[j+1])
            );
        end

        if (k == 0) begin : g_src
            // Stage 0 only advances when in_ready is high, so in_valid alone
            // is the accept condition here; otherwise a bubble is loaded.
            assign valid_in = in_valid;
            assign a_seg    = A[S-1:0];
            assign b_seg    = B[S-1:0];
            assign bc[0]    = Bin;
            assign diff_d   = d_seg;
        end else begin : g_src
            assign valid_in = g_stage[k-1].valid_q;
            assign a_seg    = g_stage[k-1].g_ops.a_rem_q[S-1:0];
            assign b_seg    = g_stage[k-1].g_ops.b_rem_q[S-1:0];
            assign bc[0]    = g_stage[k-1].borrow_q;
            assign diff_d   = {d_seg, g_stage[k-1].diff_q};
        end

        // Operand skew registers: the upper, not yet resolved bits of A and B.
        // The last stage has nothing left to carry.
        if (RW > 0) begin : g_ops
            logic [RW-1:0] a_rem_d;
            logic [RW-1:0] b_rem_d;
            logic [RW-1:0] a_rem_q;
            logic [RW-1:0] b_rem_q;

            if (k == 0) begin : g_rem_src
                assign a_rem_d = A[WIDTH-1:S];
                assign b_rem_d = B[WIDTH-1:S];
            end else begin : g_rem_src
                assign a_rem_d = g_stage[k-1].g_ops.a_rem_q[RW+S-1:S];
                assign b_rem_d = g_stage[k-1].g_ops.b_rem_q[RW+S-1:S];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else if (!stall) begin
                    a_rem_q <= a_rem_d;
                    b_rem_q <= b_rem_d;
                end
            end
        end

        // NOTE: every pipeline register, data included, is cleared by reset so
        // that Diff/Bout read 0 out of reset and no stale beat data survives;
        // these are flops, not a memory array, so the reset costs nothing odd.
        // NOTE: sequential state uses non-blocking assignments so that every
        // stage samples its predecessor's pre-edge value, which is what makes
        // the registers behave as a shift pipeline.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q  <= 1'b0;
                borrow_q <= 1'b0;
                diff_q   <= '0;
            end else if (!stall) begin
                valid_q  <= valid_in;
                borrow_q <= bc[S];
                diff_q   <= diff_d;
            end
        end

`ifdef SUB_OVERFLOW_EN
        // The operand MSBs arrive at the last stage through the skew registers,
        // so overflow is formed there from the MSB slice and registered with Diff.
        if (k == L - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q <= (a_seg[S-1] ^ b_seg[S-1]) & (a_seg[S-1] ^ d_seg[S-1]);
                end
            end
        end
`endif
    end

    // Outputs come straight from the last stage registers.
    assign out_valid = g_stage[L-1].valid_q;
    assign Diff      = g_stage[L-1].diff_q;
    assign Bout      = g_stage[L-1].borrow_q;
`ifdef SUB_OVERFLOW_EN
    assign Ovf       = g_stage[L-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_ripple_subtractor.sv
// -----------------------------------------------------------------------------
// tb_pipelined_ripple_subtractor
//
// Self-checking bench for pipelined_ripple_subtractor (WIDTH = 8, STAGE_BITS = 2,
// L = 4). Expected results are computed from the operands when a beat is
// accepted, pushed to a queue, and compared when the DUT retires a result.
// The monitor also checks in_ready, output hold during stalls, latency and
// that no result appears without a pending beat. Define SUB_OVERFLOW_EN to
// also exercise the Ovf output.
// -----------------------------------------------------------------------------
module tb_pipelined_ripple_subtractor;

    localparam int W = 8;
    localparam int S = 2;
    localparam int L = W / S;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           cyc;
        int           stalls;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVERFLOW_EN
    logic         ovf;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   retired = 0;
    bit   front_seen = 1'b0;
    bit   held_valid = 1'b0;
    logic [W-1:0] held_diff;
    logic         held_bout;
    exp_t exp_q[$];
    exp_t e;

    pipelined_ripple_subtractor #(.WIDTH(W), .STAGE_BITS(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (diff),
`ifdef SUB_OVERFLOW_EN
        .Ovf       (ovf),
`endif
        .Bout      (bout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        exp_t    r;
        logic [W:0] full;
        full     = {1'b0, av} - {1'b0, bv} - (W+1)'(bi);
        r.diff   = full[W-1:0];
        r.bout   = full[W];
        r.ovf    = (av[W-1] ^ bv[W-1]) & (av[W-1] ^ full[W-1]);
        r.cyc    = 0;
        r.stalls = 0;
        return r;
    endfunction

    // Monitor/scoreboard: runs on the falling edge, mid-cycle, and decides what
    // the next rising edge will accept and retire.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            front_seen = 1'b0;
            held_valid = 1'b0;
        end else begin
            check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (held_valid) begin
                check("hold_valid", 32'(out_valid), 32'(1));
                check("hold_diff", 32'(diff), 32'(held_diff));
                check("hold_bout", 32'(bout), 32'(held_bout));
            end
            held_valid = 1'b0;
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(out_valid), 32'(0));
            end else if (out_valid) begin
                e = exp_q[0];
                if (!front_seen) begin
                    check("latency", 32'(cyc - e.cyc), 32'(L + stall_cnt - e.stalls));
                    front_seen = 1'b1;
                end
                if (out_ready) begin
                    check("diff", 32'(diff), 32'(e.diff));
                    check("bout", 32'(bout), 32'(e.bout));
`ifdef SUB_OVERFLOW_EN
                    check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                    void'(exp_q.pop_front());
                    front_seen = 1'b0;
                    retired++;
                end else begin
                    held_diff  = diff;
                    held_bout  = bout;
                    held_valid = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                e        = model(a, b, bin);
                e.cyc    = cyc;
                e.stalls = stall_cnt;
                exp_q.push_back(e);
            end
            if (out_valid && !out_ready) stall_cnt++;
        end
    end

    // Present one beat and hold it until accepted. Starts and ends just after
    // a rising edge; inputs are driven with blocking assignments.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        bit acc = 1'b0;
        int guard = 0;
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
        end
        check("send_timeout", 32'(acc), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int  base_ret;
        int  base_stall;
        bit  found;
        bit  rand_done;

        rst_n = 1'b0; in_valid = 1'b1; a = 8'h5A; b = 8'h33; bin = 1'b1; out_ready = 1'b1;

        // Reset held for three edges with in_valid high.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_diff", 32'(diff), 32'(0));
        check("rst_bout", 32'(bout), 32'(0));
`ifdef SUB_OVERFLOW_EN
        check("rst_ovf", 32'(ovf), 32'(0));
`endif
        rst_n = 1'b1; in_valid = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk); #1;

        // Single beats, borrow-in and full ripple.
        send(8'h05, 8'h03, 1'b0); drain();
        send(8'h03, 8'h05, 1'b0); drain();
        send(8'h00, 8'h00, 1'b1);
        send(8'hFF, 8'hFF, 1'b0); drain();

        // Ten back-to-back beats, three-cycle stall when the 3rd result shows.
        base_ret   = retired;
        base_stall = stall_cnt;
        found      = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(W'(i), 8'h01, 1'b0);
            end
            begin
                for (int t = 0; t < 200 && !found; t++) begin
                    @(posedge clk); #1;
                    if (out_valid && retired == base_ret + 2) found = 1'b1;
                end
                if (found) begin
                    out_ready = 1'b0;
                    repeat (3) @(posedge clk);
                    #1 out_ready = 1'b1;
                end
            end
        join
        check("stall_trigger", 32'(found), 32'(1));
        drain();
        check("stream_count", 32'(retired - base_ret), 32'(10));
        check("stream_stalls", 32'(stall_cnt - base_stall), 32'(3));

        // Reset with three beats in flight: none of them may come out.
        send(8'h11, 8'h01, 1'b0);
        send(8'h22, 8'h02, 1'b0);
        send(8'h33, 8'h03, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("post_rst_valid", 32'(out_valid), 32'(0));
            @(posedge clk); #1;
        end
        base_ret = retired;
        send(8'h40, 8'h11, 1'b0); drain();
        check("post_rst_count", 32'(retired - base_ret), 32'(1));

`ifdef SUB_OVERFLOW_EN
        send(8'h80, 8'h01, 1'b0);
        send(8'h7F, 8'hFF, 1'b0);
        send(8'h10, 8'h01, 1'b0); drain();
`endif

        // Random operands under random backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
